// File: rtl/control_unit_pipe.sv
// RV32I subset main decoder as a one-deep pipeline stage with a valid/ready
// handshake. The decoded control bundle is registered, so every output except
// in_ready comes straight from a flop.
module control_unit_pipe #(
   parameter int ALUCTRL_W = 4,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 RegWrite,
   output logic                 MemWrite,
   output logic                 Jump,
   output logic                 Branch,
   output logic                 ALUSrc,
   output logic [1:0]           ResultSrc,
   output logic [2:0]           ImmSrc,
   output logic [2:0]           BranchCond,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 illegal,
   output logic [CNT_W-1:0]     illegal_cnt
);

   // Opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src;
      logic [1:0] result_src;
      logic [2:0] imm_src;
      logic [2:0] branch_cond;
      logic [3:0] alu_ctrl;
      logic       illegal;
   } ctrl_t;

   // Shared R/I arithmetic mapping; alt selects sub (000) or sra (101).
   function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
      logic [3:0] code;
      case (f3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   ctrl_t            dec;
   logic             dec_legal;
   ctrl_t            ctrl_d, ctrl_q;
   logic             valid_d, valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             accept;

   // Combinational decode of the incoming instruction fields
   always_comb begin
      dec       = '0;
      dec_legal = 1'b1;
      case (op)
         OP_R: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = alu_map(funct3, funct7b5);
            if (funct7b5 && funct3 != 3'b000 && funct3 != 3'b101) dec_legal = 1'b0;
         end
         OP_I: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = IMM_I;
            dec.alu_ctrl  = alu_map(funct3, funct7b5 && (funct3 == 3'b101));
            if (funct7b5 && funct3 == 3'b001) dec_legal = 1'b0;
         end
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
            dec.imm_src    = IMM_I;
            dec.alu_ctrl   = ALU_ADD;
            if (funct3 != 3'b010) dec_legal = 1'b0;
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = IMM_S;
            dec.alu_ctrl  = ALU_ADD;
            if (funct3 != 3'b010) dec_legal = 1'b0;
         end
         OP_BRANCH: begin
            dec.branch      = 1'b1;
            dec.imm_src     = IMM_B;
            dec.branch_cond = funct3;
            dec.alu_ctrl    = funct3[2] && funct3[1] ? ALU_SLTU : ALU_SUB;
            if (funct3 == 3'b010 || funct3 == 3'b011) dec_legal = 1'b0;
         end
         OP_JAL: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            dec.imm_src    = IMM_J;
         end
         OP_JALR: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            dec.alu_src    = 1'b1;
            dec.imm_src    = IMM_I;
            dec.alu_ctrl   = ALU_ADD;
            if (funct3 != 3'b000) dec_legal = 1'b0;
         end
         OP_LUI: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = IMM_U;
            dec.alu_ctrl  = ALU_PASSB;
         end
         default: dec_legal = 1'b0;
      endcase
      // An unsupported instruction carries only the illegal flag.
      if (!dec_legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Next-state selection: flush beats accept, accept beats drain, else hold
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (accept) begin
         valid_d = 1'b1;
         ctrl_d  = dec;
         if (dec.illegal && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   // Pipeline register and illegal counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid   = valid_q;
   assign RegWrite    = ctrl_q.reg_write;
   assign MemWrite    = ctrl_q.mem_write;
   assign Jump        = ctrl_q.jump;
   assign Branch      = ctrl_q.branch;
   assign ALUSrc      = ctrl_q.alu_src;
   assign ResultSrc   = ctrl_q.result_src;
   assign ImmSrc      = ctrl_q.imm_src;
   assign BranchCond  = ctrl_q.branch_cond;
   assign ALUControl  = ALUCTRL_W'(ctrl_q.alu_ctrl);
   assign illegal     = ctrl_q.illegal;
   assign illegal_cnt = cnt_q;

endmodule
